// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: shared types, codes and CRC helpers for the ALU serial codec |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int N_DATA = 8;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  localparam logic [5:0] ERR_DATA = 6'b100100;
  localparam logic [5:0] ERR_CRC  = 6'b010010;
  localparam logic [5:0] ERR_OP   = 6'b001001;

  localparam logic WTYPE_DATA = 1'b0;
  localparam logic WTYPE_CTRL = 1'b1;

  function automatic logic is_valid_op(input logic [2:0] code);
    case (code)
      OP_AND, OP_OR, OP_ADD, OP_SUB: is_valid_op = 1'b1;
      default:                       is_valid_op = 1'b0;
    endcase
  endfunction

  // MSB-first LFSR, x^4+x+1, init 0
  function automatic logic [3:0] crc4(input logic [67:0] data);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ data[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  // MSB-first LFSR, x^3+x+1, init 0
  function automatic logic [2:0] crc3(input logic [35:0] data);
    logic [2:0] c;
    logic       fb;
    c = 3'h0;
    for (int i = 35; i >= 0; i--) begin
      fb = c[2] ^ data[i];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial_word_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_serial_word_tx: 11-bit PISO word transmitter, idle-high line      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_serial_word_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [10:0] word,
  output logic        busy,
  output logic        sout
);

  logic [9:0] r_shift;
  logic [3:0] r_cnt;

  // busy drops while the stop bit is on the line, so a new load follows seamlessly
  assign busy = (r_cnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout    <= 1'b1;
      r_shift <= '1;
      r_cnt   <= 4'd0;
    end else if (load) begin
      sout    <= word[10];
      r_shift <= word[9:0];
      r_cnt   <= 4'd10;
    end else if (r_cnt != 4'd0) begin
      sout    <= r_shift[9];
      r_shift <= {r_shift[8:0], 1'b1};
      r_cnt   <= r_cnt - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_codec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_serial_codec: serial request/response front end for an ALU core   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_serial_codec #(
  parameter int N_DATA = alu_pkg::N_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        sout,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] result,
  input  logic [3:0]  flags
);
  import alu_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_WORD, S_DECODE, S_CORE_REQ, S_CORE_WAIT, S_TX
  } state_t;

  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [8:0]  r_rx_shift;
  logic [63:0] r_data;
  logic [3:0]  r_data_cnt;
  logic        r_frame_err;
  logic [2:0]  r_op_rx;
  logic [3:0]  r_crc_rx;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic [2:0]  r_crc3;
  logic        r_err_mode;
  logic [5:0]  r_err_code;
  logic [2:0]  r_tx_idx;
  logic [2:0]  r_tx_left;

  logic        w_err_data, w_err_crc, w_err_op;
  logic        w_tx_busy, w_tx_load;
  logic [10:0] w_tx_word;

  assign w_err_data = (r_data_cnt != 4'(N_DATA)) || r_frame_err;
  assign w_err_crc  = (crc4({r_data, 1'b1, r_op_rx}) != r_crc_rx);
  assign w_err_op   = !is_valid_op(r_op_rx);
  assign w_tx_load  = (r_state == S_TX) && !w_tx_busy && (r_tx_left != 3'd0);

  always_comb begin
    w_tx_word = {1'b0, WTYPE_CTRL, 1'b0, r_flags, r_crc3, 1'b1};
    if (r_err_mode) begin
      w_tx_word = {1'b0, WTYPE_CTRL, 1'b1, r_err_code, ^{1'b1, r_err_code}, 1'b1};
    end else begin
      case (r_tx_idx)
        3'd0:    w_tx_word = {1'b0, WTYPE_DATA, r_result[31:24], 1'b1};
        3'd1:    w_tx_word = {1'b0, WTYPE_DATA, r_result[23:16], 1'b1};
        3'd2:    w_tx_word = {1'b0, WTYPE_DATA, r_result[15:8],  1'b1};
        3'd3:    w_tx_word = {1'b0, WTYPE_DATA, r_result[7:0],   1'b1};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_rx_shift  <= 9'd0;
      r_data      <= 64'd0;
      r_data_cnt  <= 4'd0;
      r_frame_err <= 1'b0;
      r_op_rx     <= 3'd0;
      r_crc_rx    <= 4'd0;
      r_result    <= 32'd0;
      r_flags     <= 4'd0;
      r_crc3      <= 3'd0;
      r_err_mode  <= 1'b0;
      r_err_code  <= 6'd0;
      r_tx_idx    <= 3'd0;
      r_tx_left   <= 3'd0;
      op_valid    <= 1'b0;
      res_ready   <= 1'b0;
      A           <= 32'd0;
      B           <= 32'd0;
      op          <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!sin) begin
            r_bit_cnt <= 4'd0;
            r_state   <= S_RX_WORD;
          end
        end
        S_RX_WORD: begin
          r_rx_shift <= {r_rx_shift[7:0], sin};
          r_bit_cnt  <= r_bit_cnt + 4'd1;
          // tenth sample is the stop bit; type bit now sits in r_rx_shift[8]
          if (r_bit_cnt == 4'd9) begin
            if (!sin) r_frame_err <= 1'b1;
            if (r_rx_shift[8] == WTYPE_CTRL) begin
              r_op_rx  <= r_rx_shift[6:4];
              r_crc_rx <= r_rx_shift[3:0];
              r_state  <= S_DECODE;
            end else begin
              r_data <= {r_data[55:0], r_rx_shift[7:0]};
              if (r_data_cnt != 4'd9) r_data_cnt <= r_data_cnt + 4'd1;
              r_state <= S_IDLE;
            end
          end
        end
        S_DECODE: begin
          r_tx_idx <= 3'd0;
          if (w_err_data || w_err_crc || w_err_op) begin
            r_err_code <= w_err_data ? ERR_DATA : (w_err_crc ? ERR_CRC : ERR_OP);
            r_err_mode <= 1'b1;
            r_tx_left  <= 3'd1;
            r_state    <= S_TX;
          end else begin
            B          <= r_data[63:32];
            A          <= r_data[31:0];
            op         <= r_op_rx;
            op_valid   <= 1'b1;
            r_err_mode <= 1'b0;
            r_state    <= S_CORE_REQ;
          end
        end
        S_CORE_REQ: begin
          if (op_ready) begin
            op_valid  <= 1'b0;
            res_ready <= 1'b1;
            r_state   <= S_CORE_WAIT;
          end
        end
        S_CORE_WAIT: begin
          if (res_valid) begin
            r_result  <= result;
            r_flags   <= flags;
            r_crc3    <= crc3({result, flags});
            res_ready <= 1'b0;
            r_tx_left <= 3'd5;
            r_state   <= S_TX;
          end
        end
        S_TX: begin
          if (!w_tx_busy) begin
            if (r_tx_left != 3'd0) begin
              r_tx_left <= r_tx_left - 3'd1;
              r_tx_idx  <= r_tx_idx + 3'd1;
            end else begin
              r_data_cnt  <= 4'd0;
              r_frame_err <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  alu_serial_word_tx u_word_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_tx_load),
    .word  (w_tx_word),
    .busy  (w_tx_busy),
    .sout  (sout)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_codec.sv
`default_nettype none
// Directed table-driven bench for alu_serial_codec plus a mid-response reset sequence.
module tb_alu_serial_codec;

  logic        clk = 1'b0;
  logic        rst_n, sin, sout, op_valid, op_ready, res_valid, res_ready;
  logic [31:0] A, B, result;
  logic [2:0]  op;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;
  bit saw_opv;

  always #5 clk = ~clk;

  alu_serial_codec #(.N_DATA(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sout(sout),
    .op_valid(op_valid), .op_ready(op_ready), .A(A), .B(B), .op(op),
    .res_valid(res_valid), .res_ready(res_ready), .result(result), .flags(flags)
  );

  always @(negedge clk) if (op_valid) saw_opv = 1'b1;

  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [3:0]  crc_xor;
    int          ndata;
    int          gap;
    int          bad_stop;
    int          hold;
    logic [3:0]  flags;
    logic        ok;
    logic [5:0]  err;
  } vec_t;

  vec_t vecs[10];

  // Polynomial long division of m*x^4 by x^4+x+1
  function automatic logic [3:0] ref_crc4(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_crc3(input logic [35:0] m);
    logic [38:0] r;
    r = {m, 3'b000};
    for (int i = 38; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [31:0] model_alu(input vec_t v);
    case (v.op)
      3'b000:  return v.a & v.b;
      3'b001:  return v.a | v.b;
      3'b100:  return v.a + v.b;
      default: return v.a - v.b;
    endcase
  endfunction

  function automatic logic [10:0] exp_good(input logic [31:0] r, input logic [3:0] f, input int i);
    if (i < 4) return {1'b0, 1'b0, r[31-8*i -: 8], 1'b1};
    return {3'b010, f, ref_crc3({r, f}), 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic typ, input logic [7:0] pay, input logic stop);
    logic [10:0] w;
    w = {1'b0, typ, pay, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = w[i];
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [63:0] d;
    logic [3:0]  c;
    d = {v.b, v.a};
    for (int k = 0; k < v.ndata; k++) begin
      send_word(1'b0, (k < 8) ? d[63-8*k -: 8] : 8'h5A, (k == v.bad_stop) ? 1'b0 : 1'b1);
      repeat (v.gap) begin
        @(negedge clk);
        sin = 1'b1;
      end
    end
    c = ref_crc4({v.b, v.a, 1'b1, v.op}) ^ v.crc_xor;
    send_word(1'b1, {1'b0, v.op, c}, 1'b1);
    @(negedge clk);
    sin = 1'b1;
  endtask

  task automatic recv_word(output logic [10:0] w);
    int n;
    n = 0;
    w = '1;
    do begin
      @(negedge clk);
      n++;
    end while (sout !== 1'b0 && n < 60);
    if (sout !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL rx_start: sout=%b after %0d cycles, want start bit 0", sout, n);
      return;
    end
    w[10] = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      w[i] = sout;
    end
  endtask

  // Plays the ALU core for a frame that decodes cleanly; returns the result it supplied
  task automatic serve_core(input vec_t v, input int idx, output logic [31:0] r);
    int   n;
    logic stable;
    n = 0;
    while (!op_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d op_valid_rise", idx), op_valid, 1);
    check($sformatf("v%0d A", idx), A, v.a);
    check($sformatf("v%0d B", idx), B, v.b);
    check($sformatf("v%0d op", idx), op, v.op);
    stable = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (A !== v.a || B !== v.b || op !== v.op || op_valid !== 1'b1 || sout !== 1'b1) stable = 1'b0;
    end
    if (v.hold > 0) check($sformatf("v%0d hold_stable", idx), stable, 1);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check($sformatf("v%0d op_valid_drop", idx), op_valid, 0);
    r = model_alu(v);
    res_valid = 1'b1;
    result    = r;
    flags     = v.flags;
    n = 0;
    while (!res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d res_ready", idx), res_ready, 1);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [10:0] w;
    logic [31:0] r;
    saw_opv = 1'b0;
    send_frame(v);
    if (v.ok) begin
      serve_core(v, idx, r);
      for (int i = 0; i < 5; i++) begin
        recv_word(w);
        check($sformatf("v%0d resp_word%0d", idx, i), w, exp_good(r, v.flags, i));
      end
    end else begin
      recv_word(w);
      check($sformatf("v%0d err_word", idx), w, {3'b011, v.err, ^{1'b1, v.err}, 1'b1});
      check($sformatf("v%0d no_op_valid", idx), saw_opv, 0);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] w;
    logic [31:0] r;
    logic        stable;
    int          n;

    //         b             a             op      xor   nd gap bad hold flags ok  err
    vecs[0] = '{32'd2,        32'd1,        3'b100, 4'h0, 8, 0, -1, 0,  4'h0, 1'b1, 6'b000000};
    vecs[1] = '{32'd2,        32'd1,        3'b100, 4'h0, 7, 0, -1, 0,  4'h0, 1'b0, 6'b100100};
    vecs[2] = '{32'd2,        32'd1,        3'b100, 4'h1, 8, 0, -1, 0,  4'h0, 1'b0, 6'b010010};
    vecs[3] = '{32'd2,        32'd1,        3'b111, 4'h1, 8, 0, -1, 0,  4'h0, 1'b0, 6'b010010};
    vecs[4] = '{32'd2,        32'd1,        3'b010, 4'h0, 8, 0, -1, 0,  4'h0, 1'b0, 6'b001001};
    vecs[5] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 4'h0, 8, 2, -1, 20, 4'hA, 1'b1, 6'b000000};
    vecs[6] = '{32'h00000005, 32'h80000000, 3'b101, 4'h0, 8, 0, -1, 0,  4'h5, 1'b1, 6'b000000};
    vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 3'b001, 4'h0, 8, 1, -1, 0,  4'hF, 1'b1, 6'b000000};
    vecs[8] = '{32'd2,        32'd1,        3'b100, 4'h0, 9, 0, -1, 0,  4'h0, 1'b0, 6'b100100};
    vecs[9] = '{32'd2,        32'd1,        3'b100, 4'h0, 8, 0, 3,  0,  4'h0, 1'b0, 6'b100100};

    rst_n = 1'b0; sin = 1'b1; op_ready = 1'b0; res_valid = 1'b0; result = '0; flags = '0;
    repeat (2) @(negedge clk);
    check("reset sout", sout, 1);
    check("reset op_valid", op_valid, 0);
    check("reset res_ready", res_ready, 0);
    check("reset A", A, 0);
    check("reset B", B, 0);
    check("reset op", op, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset in the middle of the third response word
    send_frame(vecs[0]);
    serve_core(vecs[0], 100, r);
    for (int i = 0; i < 2; i++) begin
      recv_word(w);
      check($sformatf("rst_seq word%0d", i), w, exp_good(r, vecs[0].flags, i));
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sout !== 1'b0 && n < 60);
    check("rst_seq third_start", sout, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_seq sout_async", sout, 1);
    check("rst_seq op_valid", op_valid, 0);
    check("rst_seq res_ready", res_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (sout !== 1'b1) stable = 1'b0;
    end
    check("rst_seq line_idle", stable, 1);
    run_vec(vecs[0], 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_serial_codec.md
ALU_SERIAL_CODEC -- requirements
Module: alu_serial_codec

Interface
REQ-001 SHALL have parameter N_DATA, default 8: data words per valid frame, four bytes of B then four bytes of A.
REQ-002 SHALL have ports clk in 1 (the single clock) and rst_n in 1 (asynchronous, active-low reset).
REQ-003 SHALL have port sin in 1: serial request line, idle high, sampled on posedge clk.
REQ-004 SHALL have port sout out 1: serial response line, idle high, driven from a flop.
REQ-005 SHALL have ports op_valid out 1, op_ready in 1, A out 32, B out 32 and op out 3, forming the core request handshake.
REQ-006 SHALL have ports res_valid in 1, res_ready out 1, result in 32 and flags in 4, forming the core result handshake.

Function
REQ-007 Word format SHALL be 11 bits sent MSB first: start 0, type bit (0 = data, 1 = control), 8 payload bits, stop 1.
REQ-008 Data word payload SHALL be one operand byte; bytes SHALL arrive in order B[31:24] .. B[7:0], then A[31:24] .. A[7:0].
REQ-009 Command word SHALL be {0, 1, 0, op[2:0], crc4[3:0], 1}.
REQ-010 crc4 SHALL be CRC over {B, A, 1'b1, op} with polynomial x^4+x+1 and init 0.
REQ-011 RX FSM states SHALL be IDLE, RX_WORD, DECODE, CORE_REQ, CORE_WAIT and TX.
REQ-012 IDLE -> RX_WORD SHALL occur on sampled sin==0; RX_WORD SHALL take the next 10 samples.
REQ-013 Words MAY be back-to-back or separated by any number of idle-high cycles.
REQ-014 A data word SHALL increment a 4-bit data counter, saturating at 9, and shift the byte into a 64-bit register.
REQ-015 A stop bit sampled as 0 SHALL set a framing flag; the frame SHALL still complete at the command word.
REQ-016 At the command word the block SHALL enter DECODE and check errors with priority DATA > CRC > OP.
REQ-017 ERR_DATA SHALL be raised when the count != N_DATA or the framing flag is set.
REQ-018 ERR_CRC SHALL be raised on crc4 mismatch.
REQ-019 ERR_OP SHALL be raised when op is not one of AND=000, OR=001, ADD=100, SUB=101.
REQ-020 Error codes SHALL be ERR_DATA=6'b100100, ERR_CRC=6'b010010, ERR_OP=6'b001001.
REQ-021 With no error, op_valid SHALL rise the cycle after DECODE, with A, B and op stable until op_valid && op_ready.
REQ-022 In CORE_WAIT, res_ready SHALL be high and result and flags SHALL be captured on res_valid && res_ready.
REQ-023 Transmission SHALL start the cycle after capture (or after DECODE on error); sout SHALL change only on posedge clk.
REQ-024 A good response SHALL be 4 data words of result, MSB byte first, then {0, 1, 0, flags, crc3, 1}.
REQ-025 crc3 SHALL be CRC over {result, flags} with x^3+x+1 and init 0.
REQ-026 An error response SHALL be a single word {0, 1, 1, err[5:0], parity, 1}, with parity = ^{1'b1, err}.
REQ-027 Words SHALL be transmitted back-to-back; after the last stop bit sout SHALL stay 1 and the FSM SHALL return to IDLE.
REQ-028 sin SHALL be ignored from DECODE until TX completes (half-duplex).
REQ-029 The data counter and framing flag SHALL clear on return to IDLE.

Reset
REQ-030 On rst_n low, sout SHALL be 1, op_valid and res_ready 0, A, B and op 0, all counters 0 and the FSM in IDLE, asynchronously.
REQ-031 Reset mid-frame or mid-TX SHALL abort with no partial response; after release the first sin==0 SHALL start a new word.

Structure
REQ-032 operation_t, the error codes, word-type constants, N_DATA, and crc4/crc3 functions SHALL live in alu_pkg.
REQ-033 An 11-bit parallel-in serial-out word transmitter SHALL be sub-module alu_serial_word_tx (load, busy, sout).

Verification
REQ-034 B=2, A=1, ADD, correct crc4, core returns 3 with flags 0000 -> response 00000000 00000000 00000000 00000011 + control word with crc3.
REQ-035 7 data words + command -> single error word, err=100100, parity 1; op_valid never asserted.
REQ-036 8 words, crc4 XOR 4'b0001 -> err=010010; with bad crc AND op=111 -> still 010010.
REQ-037 Correct frame with op=010 -> err=001001.
REQ-038 op_ready held low 20 cycles -> A, B and op stable; sout stays 1 throughout.
REQ-039 rst_n pulsed during the third response word -> sout=1 at once, no further words; next frame answered normally.
